// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder for load/store ops coming out of ID/EX.
// Non-memory ops are registered straight through to writeback. A load or store
// runs one req/ack transaction on the data bus while stall_o holds the upstream
// pipeline. After the bus completes, the unit spends one DONE cycle in which EX
// still presents the finished op.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   mem_valid_i, mem_rw_i    memory op request; 1 = store, 0 = load
//   mem_addr_i, mem_wdata_i  effective address and store data
//   alu_result_i             result for non-memory ops
//   reg_write_addr_i/_enable_i  destination register and its write enable
//   stall_o                  combinational hold to the upstream stages
//   bus_req_o/we_o/addr_o/wdata_o  registered bus request, held until ack
//   bus_ack_i, bus_rdata_i   one-cycle completion pulse and load data
//   wb_data_o, reg_write_addr_o, reg_write_enable_o  writeback outputs
//   mem_err_o                bus timeout flag, high only during DONE
//
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction that sees
// TIMEOUT_CYCLES bus cycles without an ack. Without it, mem_err_o is tied to 0.

module mem_access_unit #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              mem_rw_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [4:0]        reg_write_addr_i,
    input  logic              reg_write_enable_i,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [4:0]        reg_write_addr_o,
    output logic              reg_write_enable_o,
    output logic              mem_err_o
);

    // Guard against a zero timeout, which would leave no cycle in which an ack could land.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              en_q, en_d;
    logic              bus_req_d;
    logic              bus_we_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_d;
    logic [DATA_W-1:0] wb_data_d;
    logic [4:0]        wb_addr_d;
    logic              wb_en_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
`endif

    // Upstream holds during the request cycle and the whole bus wait; reset releases it at once.
    assign stall_o = rst & (((state_q == IDLE) & mem_valid_i) | (state_q == BUS));

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            rd_q               <= '0;
            en_q               <= 1'b0;
            bus_req_o          <= 1'b0;
            bus_we_o           <= 1'b0;
            bus_addr_o         <= '0;
            bus_wdata_o        <= '0;
            wb_data_o          <= '0;
            reg_write_addr_o   <= '0;
            reg_write_enable_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q              <= '0;
            mem_err_o          <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            rd_q               <= rd_d;
            en_q               <= en_d;
            bus_req_o          <= bus_req_d;
            bus_we_o           <= bus_we_d;
            bus_addr_o         <= bus_addr_d;
            bus_wdata_o        <= bus_wdata_d;
            wb_data_o          <= wb_data_d;
            reg_write_addr_o   <= wb_addr_d;
            reg_write_enable_o <= wb_en_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q              <= cnt_d;
            mem_err_o          <= err_d;
`endif
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign mem_err_o = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        en_d        = en_q;
        bus_req_d   = bus_req_o;
        bus_we_d    = bus_we_o;
        bus_addr_d  = bus_addr_o;
        bus_wdata_d = bus_wdata_o;
        wb_data_d   = wb_data_o;
        wb_addr_d   = reg_write_addr_o;
        wb_en_d     = reg_write_enable_o;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    // Bus registers double as the latched address, data and direction.
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_rw_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    rd_d        = reg_write_addr_i;
                    en_d        = reg_write_enable_i;
                    wb_en_d     = 1'b0;
                    state_d     = BUS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else begin
                    wb_data_d = alu_result_i;
                    wb_addr_d = reg_write_addr_i;
                    wb_en_d   = reg_write_enable_i;
                end
            end

            BUS: begin
                // An ack always wins over a timeout that would expire on the same cycle.
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (!bus_we_o) begin
                        wb_data_d = bus_rdata_i;
                        wb_addr_d = rd_q;
                        wb_en_d   = en_q;
                    end else begin
                        wb_en_d   = 1'b0;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    wb_en_d   = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            DONE: begin
                // EX still shows the completed op here, so inputs are ignored.
                wb_en_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs change 1 time unit after each rising edge. Outputs are sampled 1 time
// unit after that, so every sample is taken away from the clock edge.

`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_rw;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] alu_result;
    logic [4:0]  rd_in;
    logic        en_in;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic [63:0] wb_data;
    logic [4:0]  rd_out;
    logic        en_out;
    logic        mem_err;

    int n_tests;
    int n_fail;
    int stall_cnt;

    mem_access_unit #(
        .DATA_W(64),
        .ADDR_W(64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_valid_i        (mem_valid),
        .mem_rw_i           (mem_rw),
        .mem_addr_i         (mem_addr),
        .mem_wdata_i        (mem_wdata),
        .alu_result_i       (alu_result),
        .reg_write_addr_i   (rd_in),
        .reg_write_enable_i (en_in),
        .stall_o            (stall),
        .bus_req_o          (bus_req),
        .bus_we_o           (bus_we),
        .bus_addr_o         (bus_addr),
        .bus_wdata_o        (bus_wdata),
        .bus_ack_i          (bus_ack),
        .bus_rdata_i        (bus_rdata),
        .wb_data_o          (wb_data),
        .reg_write_addr_o   (rd_out),
        .reg_write_enable_o (en_out),
        .mem_err_o          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [63:0] a,
                          input logic [63:0] wd, input logic [4:0] rd, input logic en);
        mem_valid = v;
        mem_rw    = rw;
        mem_addr  = a;
        mem_wdata = wd;
        rd_in     = rd;
        en_in     = en;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        mem_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_result = '0;
        rd_in      = '0;
        en_in      = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;

        // Reset values
        #12;
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wen", 64'(en_out), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_err", 64'(mem_err), 64'd0);
        rst = 1'b1;
        step();

        // ALU pass-through
        alu_result = 64'h1234;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd5, 1'b1);
        settle();
        check("alu_stall", 64'(stall), 64'd0);
        step();
        check("alu_wb", wb_data, 64'h1234);
        check("alu_rd", 64'(rd_out), 64'd5);
        check("alu_wen", 64'(en_out), 64'd1);

        // Load, 3 BUS cycles without ack, then ack on the 4th
        set_op(1'b1, 1'b0, 64'h80, 64'h0, 5'd7, 1'b1);
        settle();
        check("ld_stall_idle", 64'(stall), 64'd1);
        check("ld_req_idle", 64'(bus_req), 64'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("ld_req_wait", 64'(bus_req), 64'd1);
            check("ld_we_wait", 64'(bus_we), 64'd0);
            check("ld_addr_wait", bus_addr, 64'h80);
            check("ld_stall_wait", 64'(stall), 64'd1);
            check("ld_wen_bubble", 64'(en_out), 64'd0);
            step();
        end
        bus_ack   = 1'b1;
        bus_rdata = 64'hDEAD;
        settle();
        check("ld_stall_ack", 64'(stall), 64'd1);
        step();
        bus_ack   = 1'b0;
        bus_rdata = 64'h0;
        settle();
        check("ld_done_stall", 64'(stall), 64'd0);
        check("ld_done_req", 64'(bus_req), 64'd0);
        check("ld_done_wb", wb_data, 64'hDEAD);
        check("ld_done_rd", 64'(rd_out), 64'd7);
        check("ld_done_wen", 64'(en_out), 64'd1);
        check("ld_done_err", 64'(mem_err), 64'd0);
        // DONE must ignore inputs, including a fresh ALU value
        alu_result = 64'h9999;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd1, 1'b1);
        step();
        check("ld_idle_wen", 64'(en_out), 64'd0);
        check("ld_idle_wb_kept", wb_data, 64'hDEAD);

        // Store acked in the first BUS cycle; stall high for exactly 2 cycles
        stall_cnt = 0;
        set_op(1'b1, 1'b1, 64'h100, 64'hBEEF, 5'd3, 1'b1);
        settle();
        if (stall) stall_cnt++;
        step();
        check("st_we", 64'(bus_we), 64'd1);
        check("st_wdata", bus_wdata, 64'hBEEF);
        check("st_req", 64'(bus_req), 64'd1);
        if (stall) stall_cnt++;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        settle();
        if (stall) stall_cnt++;
        check("st_done_wen", 64'(en_out), 64'd0);
        check("st_done_req", 64'(bus_req), 64'd0);
        check("st_stall_cycles", 64'(stall_cnt), 64'd2);
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        step();
        check("st_idle_wen", 64'(en_out), 64'd0);

        // Stray ack in IDLE with a write to register 0
        alu_result = 64'h55;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b1);
        bus_ack = 1'b1;
        bus_rdata = 64'hAAAA;
        settle();
        check("stray_stall", 64'(stall), 64'd0);
        step();
        bus_ack = 1'b0;
        check("stray_req", 64'(bus_req), 64'd0);
        check("stray_wb", wb_data, 64'h55);
        check("stray_rd0", 64'(rd_out), 64'd0);
        check("stray_wen", 64'(en_out), 64'd1);

        // Back-to-back loads: the second request stays up through DONE
        set_op(1'b1, 1'b0, 64'h200, 64'h0, 5'd9, 1'b1);
        step();
        bus_ack = 1'b1;
        bus_rdata = 64'h1111;
        step();
        bus_ack = 1'b0;
        set_op(1'b1, 1'b0, 64'h300, 64'h0, 5'd10, 1'b1);
        settle();
        check("b2b_done_stall", 64'(stall), 64'd0);
        check("b2b_done_wb", wb_data, 64'h1111);
        check("b2b_done_rd", 64'(rd_out), 64'd9);
        step();
        check("b2b_idle_req", 64'(bus_req), 64'd0);
        check("b2b_idle_stall", 64'(stall), 64'd1);
        step();
        check("b2b_bus_req", 64'(bus_req), 64'd1);
        check("b2b_bus_addr", bus_addr, 64'h300);
        bus_ack = 1'b1;
        bus_rdata = 64'h2222;
        step();
        bus_ack = 1'b0;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        check("b2b2_wb", wb_data, 64'h2222);
        check("b2b2_rd", 64'(rd_out), 64'd10);
        check("b2b2_wen", 64'(en_out), 64'd1);
        step();

`ifdef MEM_TIMEOUT_EN
        // Timeout: no ack for 16 BUS cycles
        set_op(1'b1, 1'b0, 64'h400, 64'h0, 5'd4, 1'b1);
        step();
        for (int i = 0; i < 16; i++) begin
            check("to_req_wait", 64'(bus_req), 64'd1);
            check("to_err_wait", 64'(mem_err), 64'd0);
            step();
        end
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        check("to_req_drop", 64'(bus_req), 64'd0);
        check("to_err", 64'(mem_err), 64'd1);
        check("to_wen", 64'(en_out), 64'd0);
        step();
        check("to_err_clear", 64'(mem_err), 64'd0);

        // An ack in the 16th BUS cycle wins over the timeout
        set_op(1'b1, 1'b0, 64'h500, 64'h0, 5'd6, 1'b1);
        step();
        for (int i = 0; i < 15; i++) step();
        check("to_ack_req", 64'(bus_req), 64'd1);
        bus_ack = 1'b1;
        bus_rdata = 64'h3333;
        step();
        bus_ack = 1'b0;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0);
        check("to_ack_err", 64'(mem_err), 64'd0);
        check("to_ack_wb", wb_data, 64'h3333);
        check("to_ack_wen", 64'(en_out), 64'd1);
        step();
`else
        check("no_to_err", 64'(mem_err), 64'd0);
`endif

        // Reset in the middle of a bus transaction
        set_op(1'b1, 1'b0, 64'h600, 64'h0, 5'd8, 1'b1);
        step();
        check("mid_req", 64'(bus_req), 64'd1);
        rst = 1'b0;
        settle();
        check("mid_rst_req", 64'(bus_req), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_wen", 64'(en_out), 64'd0);
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 5'd2, 1'b1);
        alu_result = 64'h7777;
        settle();
        rst = 1'b1;
        step();
        check("post_rst_req", 64'(bus_req), 64'd0);
        check("post_rst_stall", 64'(stall), 64'd0);
        check("post_rst_wb", wb_data, 64'h7777);
        check("post_rst_wen", 64'(en_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
